// File: rtl/button_if.sv
// Debounced-button link: stable level from the debouncer, timed events back to control logic.
interface button_if;
    logic btn_level;
    logic click;
    logic dbl_click;
    logic long_press;
    logic repeat_tick;
    logic busy;

    modport master (
        output btn_level,
        input  click,
        input  dbl_click,
        input  long_press,
        input  repeat_tick,
        input  busy
    );

    modport slave (
        input  btn_level,
        output click,
        output dbl_click,
        output long_press,
        output repeat_tick,
        output busy
    );
endinterface

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle click / double-click / long-press events.
// Define BUTTON_AUTO_REPEAT_EN to emit repeat_tick pulses while a long press is held.
module button_event_decoder #(
    parameter int unsigned LONG_TICKS    = 50000000,
    parameter int unsigned DBL_GAP_TICKS = 25000000,
    parameter int unsigned REPEAT_TICKS  = 10000000,
    parameter int unsigned CNT_W         = 27
) (
    input logic      clk,
    input logic      rst,
    button_if.slave  bus
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StPress1 = 3'd1;
    localparam logic [2:0] StWait2  = 3'd2;
    localparam logic [2:0] StPress2 = 3'd3;
    localparam logic [2:0] StHeld   = 3'd4;

    localparam int unsigned MaxLd   = (LONG_TICKS > DBL_GAP_TICKS) ? LONG_TICKS : DBL_GAP_TICKS;
    localparam int unsigned MaxTick = (MaxLd > REPEAT_TICKS) ? MaxLd : REPEAT_TICKS;

    localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] GapLast  = CNT_W'(DBL_GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] CntMax   = CNT_W'(MaxTick);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             level_prev_q;
    logic             click_q, click_d;
    logic             dbl_q, dbl_d;
    logic             long_q, long_d;
    logic             busy_q;
    logic             rise, fall;

    assign rise    = bus.btn_level & ~level_prev_q;
    assign fall    = ~bus.btn_level & level_prev_q;
    // Never wraps; the thresholds force a transition long before this bound matters.
    assign cnt_inc = (cnt_q >= CntMax) ? cnt_q : cnt_q + 1'b1;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RepLast = CNT_W'(REPEAT_TICKS - 1);
    logic rep_q, rep_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        click_d = 1'b0;
        dbl_d   = 1'b0;
        long_d  = 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
        rep_d   = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StPress1;
                    cnt_d   = CNT_W'(1);
                end
            end
            StPress1: begin
                // A release on the threshold cycle counts as a short press.
                if (fall) begin
                    state_d = StWait2;
                    cnt_d   = CNT_W'(1);
                end else if (bus.btn_level) begin
                    if (cnt_q == LongLast) begin
                        long_d  = 1'b1;
                        state_d = StHeld;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            StWait2: begin
                // A second press on the timeout cycle still makes a double-click.
                if (rise) begin
                    state_d = StPress2;
                    cnt_d   = '0;
                end else if (!bus.btn_level) begin
                    if (cnt_q == GapLast) begin
                        click_d = 1'b1;
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            StPress2: begin
                if (fall) begin
                    dbl_d   = 1'b1;
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            StHeld: begin
                if (fall) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
`ifdef BUTTON_AUTO_REPEAT_EN
                else if (bus.btn_level) begin
                    if (cnt_q == RepLast) begin
                        rep_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
`endif
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            level_prev_q <= 1'b1;
            click_q      <= 1'b0;
            dbl_q        <= 1'b0;
            long_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            level_prev_q <= bus.btn_level;
            click_q      <= click_d;
            dbl_q        <= dbl_d;
            long_q       <= long_d;
            busy_q       <= (state_d != StIdle);
        end
    end

`ifdef BUTTON_AUTO_REPEAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_q <= 1'b0;
        end else begin
            rep_q <= rep_d;
        end
    end
    assign bus.repeat_tick = rep_q;
`else
    assign bus.repeat_tick = 1'b0;
`endif

    assign bus.click      = click_q;
    assign bus.dbl_click  = dbl_q;
    assign bus.long_press = long_q;
    assign bus.busy       = busy_q;

endmodule
